mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Initiator for the unified memory port. Arbitrates between the CPU instruction-fetch client (read-only) and the data client (read/write), and issues one transaction at a time over the re/we/addr/wdata/rd_data/rdy interface. It returns read data and a completion pulse to the granted client, and flags a timeout if the memory never signals completion.

Parameters:
ADDR_W, 16, address width of clients and memory.
DATA_W, 32, data width of clients and memory.
TMO_CYC, 15, max WAIT cycles before timeout abort (must be ≥4).

Ports:
clk  in  1  clock; all logic on rising edge.
rst_n  in  1  synchronous active-low reset.
i_req  in  1  instruction read request; held until i_done.
i_addr  in  ADDR_W  instruction address; stable while i_req.
i_rd_data  out  DATA_W  instruction read data; valid with i_done.
i_done  out  1  one-cycle completion pulse to instruction client.
d_req  in  1  data request; held until d_done.
d_we  in  1  1 = write, 0 = read; stable while d_req.
d_addr  in  ADDR_W  data address.
d_wdata  in  DATA_W  write data.
d_rd_data  out  DATA_W  data read result; valid with d_done.
d_done  out  1  one-cycle completion pulse to data client.
tmo  out  1  pulses with the done pulse when the transaction timed out.
mem_re  out  1  memory read strobe.
mem_we  out  1  memory write strobe.
mem_addr  out  ADDR_W  memory address.
mem_wdata  out  DATA_W  memory write data.
mem_rd_data  in  DATA_W  memory read data.
mem_rdy  in  1  memory ready; low while busy.

Behaviour:
- Reset (sync, rst_n=0 at posedge): state=IDLE, mem_re=mem_we=0, mem_addr=0, mem_wdata=0, i_done=d_done=tmo=0, i_rd_data=d_rd_data=0, grant pointer=instruction.
- All outputs are registered.
- States:
  - IDLE: if mem_rdy=1 and any req, grant per arbitration, latch addr/wdata/we onto mem_* and go ISSUE. If mem_rdy=0 (memory still busy, e.g. after a mid-op reset), stay in IDLE and issue nothing.
  - ISSUE: mem_re or mem_we=1 for exactly this one cycle. mem_rdy is ignored in this cycle. Next state is WAIT.
  - WAIT: mem_re=mem_we=0. mem_addr and mem_wdata are held. Timeout counter increments each cycle. If mem_rdy=1, capture mem_rd_data (reads only) into the granted client's rd_data and go RESP. If the counter reaches TMO_CYC, go RESP with the timeout flag set.
  - RESP: pulse the granted client's done for one cycle, plus tmo if the timeout flag is set. Then go IDLE.
- A new grant is possible in the cycle after RESP. The client must drop req on the done cycle; a req still high after done is a new request.
- Latency against the 4-clock memory: req seen at cycle 0 → ISSUE at cycle 1 → WAIT at cycles 2–4 (mem_rdy=1 at cycle 4) → done at cycle 5. Back-to-back throughput is 1 transaction per 6 cycles.
- Writes leave d_rd_data unchanged. On a timeout, rd_data is unchanged.
- Simultaneous i_req and d_req: arbitration decides (see Optional Feature). The loser stays pending; its req is never dropped.
- Requests arriving during ISSUE, WAIT or RESP wait for IDLE.
- Reset mid-transaction: the controller returns to IDLE and the completion is lost (no done pulse). The next issue waits for mem_rdy=1.

Optional Feature:
ARB_RR_EN.
- Defined: round-robin arbitration. The grant pointer toggles to the other client after each completed grant; on contention the client not granted last wins.
- Undefined: fixed priority, data client always wins over instruction; the grant pointer is unused.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum {IDLE, ISSUE, WAIT, RESP};
  - client-select enum {GNT_I, GNT_D};
  - default ADDR_W/DATA_W constants.
- One sub-module, mem_arb_grant: combinational grant selection from i_req, d_req and the grant pointer, with the ARB_RR_EN logic. The FSM, counter and datapath stay in mem_arbiter.

Test Plan:
- Instruction read: mem preloaded 0x0013 @0x0010, 0xABCD @0x0011; i_req, i_addr=0x0010 at cycle 0 → mem_re high cycle 1 only; i_done at cycle 5 with i_rd_data=0xABCD0013; tmo=0.
- Data write then read: d_we=1, d_addr=0x0200, d_wdata=0x1234 → mem_we one cycle, d_done at cycle 5. Then read 0x0200 → d_rd_data[15:0]=0x1234.
- Contention: i_req and d_req both high at cycle 0 → without ARB_RR_EN, d served first, i served next (i_done at cycle 11). With ARB_RR_EN, after reset i and d alternate on repeated contention.
- Timeout: memory model holds mem_rdy=0 → done pulse with tmo=1 after TMO_CYC WAIT cycles; rd_data unchanged.
- Mid-op reset: rst_n=0 during WAIT → no done pulse, outputs at reset values. With mem_rdy held 0 for 2 more cycles, a new i_req issues only once mem_rdy=1.
- Addr stability: i_addr changed while in WAIT → mem_addr keeps its latched value until RESP.

Source files
------------

// File: rtl/mem_arb_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Brief    : Shared types and default widths for the unified memory arbiter.
//            Arbitration mode is selected by macro ARB_RR_EN.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    localparam int c_addr_w_dflt = 16;
    localparam int c_data_w_dflt = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } gnt_t;

endpackage
`default_nettype wire

// File: rtl/mem_arb_grant.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mem_arb_grant
// Brief    : Combinational client selection. ARB_RR_EN defined: round-robin
//            via the grant pointer; undefined: data client has fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arb_grant
    import mem_arb_pkg::*;
(
    input  logic i_inst_req,
    input  logic i_data_req,
    input  gnt_t i_ptr,
    output gnt_t o_gnt,
    output logic o_any
);

`ifdef ARB_RR_EN
    always_comb begin
        o_any = i_inst_req | i_data_req;
        o_gnt = GNT_I;
        if (i_inst_req && i_data_req) begin
            o_gnt = i_ptr;
        end else if (i_data_req) begin
            o_gnt = GNT_D;
        end
    end
`else
    logic w_unused_ptr;
    assign w_unused_ptr = i_ptr;

    always_comb begin
        o_any = i_inst_req | i_data_req;
        o_gnt = GNT_I;
        if (i_data_req) begin
            o_gnt = GNT_D;
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Single-outstanding memory initiator shared by instruction and data
//            clients, with completion timeout. Macro ARB_RR_EN selects RR.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = c_addr_w_dflt,
    parameter int DATA_W  = c_data_w_dflt,
    parameter int TMO_CYC = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rd_data,
    output logic              i_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rd_data,
    output logic              d_done,
    output logic              tmo,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rd_data,
    input  logic              mem_rdy
);

    localparam int                 c_cnt_w    = $clog2(TMO_CYC + 1);
    localparam logic [c_cnt_w-1:0] c_tmo_last = c_cnt_w'(TMO_CYC - 1);

    arb_state_t         r_state, w_state;
    gnt_t               r_gnt, w_gnt;
    gnt_t               r_ptr, w_ptr;
    logic               r_we, w_we;
    logic [c_cnt_w-1:0] r_cnt, w_cnt;
    logic               r_mem_re, w_mem_re;
    logic               r_mem_we, w_mem_we;
    logic [ADDR_W-1:0]  r_mem_addr, w_mem_addr;
    logic [DATA_W-1:0]  r_mem_wdata, w_mem_wdata;
    logic [DATA_W-1:0]  r_i_rd, w_i_rd;
    logic [DATA_W-1:0]  r_d_rd, w_d_rd;
    logic               r_i_done, w_i_done;
    logic               r_d_done, w_d_done;
    logic               r_tmo, w_tmo;
    gnt_t               w_sel;
    logic               w_any;

    mem_arb_grant u_grant (
        .i_inst_req (i_req),
        .i_data_req (d_req),
        .i_ptr      (r_ptr),
        .o_gnt      (w_sel),
        .o_any      (w_any)
    );

    always_comb begin
        w_state     = r_state;
        w_gnt       = r_gnt;
        w_ptr       = r_ptr;
        w_we        = r_we;
        w_cnt       = r_cnt;
        w_mem_re    = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_addr  = r_mem_addr;
        w_mem_wdata = r_mem_wdata;
        w_i_rd      = r_i_rd;
        w_d_rd      = r_d_rd;
        w_i_done    = 1'b0;
        w_d_done    = 1'b0;
        w_tmo       = 1'b0;
        case (r_state)
            IDLE: begin
                // mem_rdy low here means an op from before a reset is still draining
                if (mem_rdy && w_any) begin
                    w_gnt   = w_sel;
                    w_cnt   = '0;
                    w_state = ISSUE;
                    if (w_sel == GNT_D) begin
                        w_mem_addr  = d_addr;
                        w_mem_wdata = d_wdata;
                        w_we        = d_we;
                        w_mem_we    = d_we;
                        w_mem_re    = ~d_we;
                    end else begin
                        w_mem_addr = i_addr;
                        w_we       = 1'b0;
                        w_mem_re   = 1'b1;
                    end
                end
            end
            ISSUE: begin
                w_state = WAIT;
            end
            WAIT: begin
                w_cnt = r_cnt + 1'b1;
                if (mem_rdy || (r_cnt == c_tmo_last)) begin
                    w_state  = RESP;
                    w_tmo    = ~mem_rdy;
                    w_i_done = (r_gnt == GNT_I);
                    w_d_done = (r_gnt == GNT_D);
                    if (mem_rdy && !r_we) begin
                        if (r_gnt == GNT_D) begin
                            w_d_rd = mem_rd_data;
                        end else begin
                            w_i_rd = mem_rd_data;
                        end
                    end
                end
            end
            RESP: begin
                w_state = IDLE;
                w_ptr   = (r_gnt == GNT_I) ? GNT_D : GNT_I;
            end
            default: begin
                w_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_gnt       <= GNT_I;
            r_ptr       <= GNT_I;
            r_we        <= 1'b0;
            r_cnt       <= '0;
            r_mem_re    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_i_rd      <= '0;
            r_d_rd      <= '0;
            r_i_done    <= 1'b0;
            r_d_done    <= 1'b0;
            r_tmo       <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_gnt       <= w_gnt;
            r_ptr       <= w_ptr;
            r_we        <= w_we;
            r_cnt       <= w_cnt;
            r_mem_re    <= w_mem_re;
            r_mem_we    <= w_mem_we;
            r_mem_addr  <= w_mem_addr;
            r_mem_wdata <= w_mem_wdata;
            r_i_rd      <= w_i_rd;
            r_d_rd      <= w_d_rd;
            r_i_done    <= w_i_done;
            r_d_done    <= w_d_done;
            r_tmo       <= w_tmo;
        end
    end

    assign mem_re    = r_mem_re;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign i_rd_data = r_i_rd;
    assign d_rd_data = r_d_rd;
    assign i_done    = r_i_done;
    assign d_done    = r_d_done;
    assign tmo       = r_tmo;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Scoreboard bench for mem_arbiter against a 4-clock memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 32;
    localparam int TMO_CYC = 15;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              i_req = 1'b0;
    logic [ADDR_W-1:0] i_addr = '0;
    logic [DATA_W-1:0] i_rd_data;
    logic              i_done;
    logic              d_req = 1'b0;
    logic              d_we = 1'b0;
    logic [ADDR_W-1:0] d_addr = '0;
    logic [DATA_W-1:0] d_wdata = '0;
    logic [DATA_W-1:0] d_rd_data;
    logic              d_done;
    logic              tmo;
    logic              mem_re;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rd_data = '0;
    logic              mem_rdy;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TMO_CYC(TMO_CYC)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_rd_data(i_rd_data), .i_done(i_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rd_data(d_rd_data), .d_done(d_done), .tmo(tmo),
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rd_data(mem_rd_data), .mem_rdy(mem_rdy)
    );

    always #5 clk = ~clk;

    // 16-bit word memory; a 32-bit access covers addr (low half) and addr+1
    logic [15:0] mem [0:4095] = '{default: 16'h0000};
    logic        preloaded = 1'b0;
    int          busy = 0;
    logic        stall = 1'b0;
    logic [11:0] ma, ma1;
    assign ma      = mem_addr[11:0];
    assign ma1     = ma + 12'd1;
    assign mem_rdy = !stall && (busy == 0);

    always @(posedge clk) begin
        if (!preloaded) begin
            mem[16]   <= 16'h0013;
            mem[17]   <= 16'hABCD;
            preloaded <= 1'b1;
        end else if (mem_re || mem_we) begin
            busy        <= 2;
            mem_rd_data <= {mem[ma1], mem[ma]};
            if (mem_we) begin
                mem[ma]  <= mem_wdata[15:0];
                mem[ma1] <= mem_wdata[31:16];
            end
        end else if (busy > 0) begin
            busy <= busy - 1;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int re_cnt = 0, we_cnt = 0, last_re_cyc = 0, last_we_cyc = 0;
    always @(negedge clk) begin
        if (mem_re) begin
            re_cnt      <= re_cnt + 1;
            last_re_cyc <= cyc;
        end
        if (mem_we) begin
            we_cnt      <= we_cnt + 1;
            last_we_cyc <= cyc;
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic        is_d;
        logic [31:0] data;
        logic        to;
        int          at;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    task automatic push_exp(input logic is_d, input logic [31:0] data, input logic to, input int at);
        exp_t e;
        e.is_d = is_d;
        e.data = data;
        e.to   = to;
        e.at   = at;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst_n && (i_done || d_done)) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", {62'd0, i_done, d_done}, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("done_client", {62'd0, i_done, d_done}, mon_e.is_d ? 64'd1 : 64'd2);
                chk(mon_e.is_d ? "d_rd_data" : "i_rd_data",
                    mon_e.is_d ? d_rd_data : i_rd_data, mon_e.data);
                chk("tmo", tmo, mon_e.to);
                chk("done_cycle", cyc, mon_e.at);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input bit is_d);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(is_d ? d_done : i_done) && n < 60);
        chk(is_d ? "d_done_seen" : "i_done_seen", is_d ? d_done : i_done, 1);
        if (is_d) d_req = 1'b0;
        else      i_req = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_mem_re"}, mem_re, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_dones"}, {i_done, d_done, tmo}, 0);
        chk({tag, "_rd_data"}, {i_rd_data, d_rd_data}, 0);
    endtask

    task automatic contention(input logic [31:0] first_data, input logic [31:0] second_data);
        int t0;
        i_addr = 16'h0010;
        d_addr = 16'h0200;
        d_we   = 1'b0;
        i_req  = 1'b1;
        d_req  = 1'b1;
        t0     = cyc;
`ifdef ARB_RR_EN
        push_exp(1'b0, first_data, 1'b0, t0 + 5);
        push_exp(1'b1, second_data, 1'b0, t0 + 11);
`else
        push_exp(1'b1, second_data, 1'b0, t0 + 5);
        push_exp(1'b0, first_data, 1'b0, t0 + 11);
`endif
        fork
            wait_done(1'b0);
            wait_done(1'b1);
        join
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int t0, r0, w0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        step();
        rst_n = 1'b1;
        step();

        // instruction read, single-cycle strobe
        r0 = re_cnt;
        i_addr = 16'h0010;
        i_req  = 1'b1;
        t0     = cyc;
        push_exp(1'b0, 32'hABCD0013, 1'b0, t0 + 5);
        wait_done(1'b0);
        chk("iread_re_count", re_cnt - r0, 1);
        chk("iread_re_cycle", last_re_cyc, t0 + 1);
        step();

        // data write: d_rd_data must stay at its reset value
        r0 = re_cnt;
        w0 = we_cnt;
        d_we = 1'b1; d_addr = 16'h0200; d_wdata = 32'h0000_1234;
        d_req = 1'b1;
        t0 = cyc;
        push_exp(1'b1, 32'h0, 1'b0, t0 + 5);
        wait_done(1'b1);
        d_we = 1'b0;
        chk("dwrite_we_count", we_cnt - w0, 1);
        chk("dwrite_we_cycle", last_we_cyc, t0 + 1);
        chk("dwrite_no_re", re_cnt - r0, 0);
        step();

        // data read-back
        d_req = 1'b1;
        t0 = cyc;
        push_exp(1'b1, 32'h0000_1234, 1'b0, t0 + 5);
        wait_done(1'b1);
        step();

        // client address changes during WAIT; memory address must hold
        i_addr = 16'h0010;
        i_req  = 1'b1;
        t0     = cyc;
        push_exp(1'b0, 32'hABCD0013, 1'b0, t0 + 5);
        step();
        step();
        i_addr = 16'h0055;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("addr_hold", mem_addr, 16'h0010);
        end
        wait_done(1'b0);
        chk("addr_hold_resp", mem_addr, 16'h0010);
        step();

        // timeout: memory never completes
        d_addr = 16'h0300;
        d_req  = 1'b1;
        t0     = cyc;
        push_exp(1'b1, 32'h0000_1234, 1'b1, t0 + 2 + TMO_CYC);
        @(negedge clk);
        @(negedge clk);
        chk("tmo_issue_re", mem_re, 1);
        stall = 1'b1;
        wait_done(1'b1);
        stall = 1'b0;
        step();

        // contention straight after reset
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        contention(32'hABCD0013, 32'h0000_1234);

        // lone data access, then contention again
        d_addr = 16'h0200;
        d_req  = 1'b1;
        t0     = cyc;
        push_exp(1'b1, 32'h0000_1234, 1'b0, t0 + 5);
        wait_done(1'b1);
        step();
`ifdef ARB_RR_EN
        contention(32'hABCD0013, 32'h0000_1234);
`else
        contention(32'hABCD0013, 32'h0000_1234);
`endif

        // reset during WAIT: completion lost, issue deferred until mem_rdy
        i_addr = 16'h0011;
        i_req  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        stall = 1'b1;
        step();
        rst_n = 1'b0;
        i_req = 1'b0;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_outputs("midop");
        step();
        r0 = re_cnt;
        i_req = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("stall_no_re", mem_re, 0);
            step();
        end
        chk("stall_re_count", re_cnt - r0, 0);
        stall = 1'b0;
        t0 = cyc;
        push_exp(1'b0, 32'h0000_ABCD, 1'b0, t0 + 5);
        wait_done(1'b0);
        chk("post_reset_re_cycle", last_re_cyc, t0 + 1);

        repeat (4) step();
        chk("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
